accelerator_read_heads_scheduler: RTL and testbench
===================================================

# accelerator_read_heads_scheduler

Controller that sequences the DNC read-vector computation r(t;i;k) = Σ_j M(t;j;k)·w(t;i;j) across all R read heads. It walks the i/k/j index space and requests one memory/weighting operand pair per step. It accumulates the dot products and emits one read-vector element per (i,k). It sits between the DNC read-heads controller and the memory/weighting operand stores.

## Interface
- DATA_SIZE, 64, operand/result width (two's complement)
- CONTROL_SIZE, 64, size and index width
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- START  in  1  start request; sampled only in IDLE
- READY  out  1  one-cycle pulse: whole run finished
- BUSY  out  1  high in every state except IDLE
- SIZE_R_IN / SIZE_N_IN / SIZE_W_IN  in  CONTROL_SIZE  head count R, memory rows N, word width W; latched on accepted START
- OP_REQ  out  1  operand request; held until OP_VALID
- OP_I_OUT / OP_J_OUT / OP_K_OUT  out  CONTROL_SIZE  requested head, row and column indices; stable while OP_REQ high
- OP_VALID  in  1  M_IN/W_IN valid for current indices
- M_IN  in  DATA_SIZE  M(j,k)
- W_IN  in  DATA_SIZE  w(i,j)
- R_OUT  out  DATA_SIZE  finished r(i,k)
- R_VALID  out  1  one-cycle strobe qualifying R_OUT
- R_I_OUT / R_K_OUT  out  CONTROL_SIZE  indices of R_OUT

## Operation
- States: IDLE, REQ, EMIT, DONE.
- IDLE:
  - START=1 and R, N, W all nonzero → latch sizes, clear i/j/k and accumulator, go to REQ.
  - START=1 and any size zero → go to DONE. No operand requests and no R_VALID are produced.
- REQ:
  - OP_REQ=1 with the current indices.
  - When OP_VALID=1 at a clock edge: acc ← acc + M_IN·W_IN.
  - After that edge: if j = N-1, go to EMIT; otherwise j ← j+1 and stay in REQ.
  - When OP_VALID=0: hold everything.
- EMIT:
  - R_VALID=1; R_OUT, R_I_OUT and R_K_OUT carry the finished sum; acc ← 0; j ← 0.
  - Advance order: k ← k+1. If k = W-1, then k ← 0 and i ← i+1.
  - If i = R-1 and k = W-1, go to DONE; otherwise go to REQ.
- DONE: READY=1 for one cycle, then go to IDLE.
- Loop order: i outermost, k middle, j innermost.
- Output order is r(0,0), r(0,1), …, r(R-1,W-1).
- START is ignored whenever BUSY=1.
- Size inputs may change after START without effect.
- OP_VALID outside REQ is ignored.
- Arithmetic: signed multiply. Accumulation behaviour is set by the Configuration section.

## Timing
- Reset values:
  - OP_REQ, R_VALID, READY, BUSY = 0.
  - R_OUT, all index outputs and the accumulator = 0.
  - State = IDLE.
- RST mid-run aborts immediately to these values. No READY is produced for the aborted run.
- START accepted at edge t: BUSY and OP_REQ are high from t+1.
- OP_VALID is accepted in the same cycle it is seen. OP_REQ stays high across consecutive j steps.
- Minimum run length: R·W·(N+1) cycles in REQ/EMIT, plus one DONE cycle.
- READY is high in the cycle after the last EMIT. BUSY drops with READY's fall (back in IDLE).
- Zero-size START at t: READY high at t+1, IDLE at t+2.
- R_OUT and the R indices are registered and hold their value until the next EMIT.

## Configuration
- ACCELERATOR_READ_HEADS_SCHEDULER_SATURATE_EN defined:
  - The full 2·DATA_SIZE product is added to a wide accumulator.
  - The value emitted on R_OUT is clamped to [−2^(DATA_SIZE−1), 2^(DATA_SIZE−1)−1].
- Undefined:
  - The product is truncated to its low DATA_SIZE bits.
  - The accumulator is DATA_SIZE bits and wraps modulo 2^DATA_SIZE.

## Structure
- Package accelerator_read_heads_scheduler_pkg holds:
  - State enum (IDLE, REQ, EMIT, DONE).
  - ZERO_CONTROL, ONE_CONTROL, ZERO_DATA.
  - Saturation min/max helper functions.
- One sub-module: accelerator_nested_index_counter.
  - Three-level j/k/i counter.
  - Inputs: sizes, clear, advance_j, advance_ik.
  - Outputs: indices, last_j, last_ik flags.
- The top level contains the FSM, accumulator and output registers.

## Test plan
- Reset: RST pulsed mid-run at N=4 → all outputs 0 next cycle; no READY; a new START runs correctly.
- Basic sum, R=1, N=2, W=1, OP_VALID tied high, operands (M,w)=(3,2),(5,4):
  - R_OUT=26 with R_VALID for one cycle and indices (0,0).
  - READY 1 cycle later; total 4 cycles from START to READY.
- Ordering, R=2, N=1, W=2, M=w=1 everywhere → four R_VALID strobes with (i,k)=(0,0),(0,1),(1,0),(1,1), each R_OUT=1.
- Back-pressure: OP_VALID low for 3 cycles mid-sum → OP_REQ and indices stay stable; result unchanged; run stretched by exactly 3 cycles.
- Zero size: START with SIZE_N_IN=0 → no OP_REQ, no R_VALID; READY at t+1.
- Overflow, DATA_SIZE=8, N=2, M=100, w=2 both steps:
  - Macro defined → R_OUT=127.
  - Macro undefined → R_OUT=0x90.
  - START asserted while BUSY is ignored in both builds.

Source files
------------

// File: rtl/accelerator_read_heads_scheduler_pkg.sv
// Shared types and constants for the DNC read-vector scheduler.
// Constants are kept wide so any instance width can slice what it needs.
package accelerator_read_heads_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned CONST_W = 256;

    localparam logic [CONST_W-1:0] ZERO_CONTROL = '0;
    localparam logic [CONST_W-1:0] ONE_CONTROL  = CONST_W'(1);
    localparam logic [CONST_W-1:0] ZERO_DATA    = '0;

    // Largest / smallest two's-complement value representable in 'width' bits.
    function automatic logic signed [CONST_W-1:0] sat_max(input int unsigned width);
        return signed'((ONE_CONTROL << (width - 1)) - ONE_CONTROL);
    endfunction

    function automatic logic signed [CONST_W-1:0] sat_min(input int unsigned width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/accelerator_read_heads_scheduler_if.sv
// Control, operand-request and result bus of the read-heads scheduler.
// master = scheduler side, slave = controller/operand-store side.
interface accelerator_read_heads_scheduler_if #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
);
    logic                           START;
    logic                           READY;
    logic                           BUSY;
    logic        [CONTROL_SIZE-1:0] SIZE_R_IN;
    logic        [CONTROL_SIZE-1:0] SIZE_N_IN;
    logic        [CONTROL_SIZE-1:0] SIZE_W_IN;
    logic                           OP_REQ;
    logic        [CONTROL_SIZE-1:0] OP_I_OUT;
    logic        [CONTROL_SIZE-1:0] OP_J_OUT;
    logic        [CONTROL_SIZE-1:0] OP_K_OUT;
    logic                           OP_VALID;
    logic signed [DATA_SIZE-1:0]    M_IN;
    logic signed [DATA_SIZE-1:0]    W_IN;
    logic signed [DATA_SIZE-1:0]    R_OUT;
    logic                           R_VALID;
    logic        [CONTROL_SIZE-1:0] R_I_OUT;
    logic        [CONTROL_SIZE-1:0] R_K_OUT;

    modport master (
        input  START, SIZE_R_IN, SIZE_N_IN, SIZE_W_IN, OP_VALID, M_IN, W_IN,
        output READY, BUSY, OP_REQ, OP_I_OUT, OP_J_OUT, OP_K_OUT,
               R_OUT, R_VALID, R_I_OUT, R_K_OUT
    );

    modport slave (
        output START, SIZE_R_IN, SIZE_N_IN, SIZE_W_IN, OP_VALID, M_IN, W_IN,
        input  READY, BUSY, OP_REQ, OP_I_OUT, OP_J_OUT, OP_K_OUT,
               R_OUT, R_VALID, R_I_OUT, R_K_OUT
    );

endinterface

// File: rtl/accelerator_read_heads_scheduler_index.sv
// Three-level index walker: j innermost, then k, then i outermost.
// j steps on advance_j; advance_ik resets j and moves to the next (i,k).
module accelerator_nested_index_counter
    import accelerator_read_heads_scheduler_pkg::*;
#(
    parameter int CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [CONTROL_SIZE-1:0] size_r,
    input  logic [CONTROL_SIZE-1:0] size_n,
    input  logic [CONTROL_SIZE-1:0] size_w,
    input  logic                    clear,
    input  logic                    advance_j,
    input  logic                    advance_ik,
    output logic [CONTROL_SIZE-1:0] idx_i,
    output logic [CONTROL_SIZE-1:0] idx_j,
    output logic [CONTROL_SIZE-1:0] idx_k,
    output logic                    last_j,
    output logic                    last_ik
);

    localparam logic [CONTROL_SIZE-1:0] ZERO = ZERO_CONTROL[CONTROL_SIZE-1:0];
    localparam logic [CONTROL_SIZE-1:0] ONE  = ONE_CONTROL[CONTROL_SIZE-1:0];

    logic last_k;
    logic last_i;

    assign last_j  = (idx_j == size_n - ONE);
    assign last_k  = (idx_k == size_w - ONE);
    assign last_i  = (idx_i == size_r - ONE);
    assign last_ik = last_i && last_k;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_i <= ZERO;
            idx_j <= ZERO;
            idx_k <= ZERO;
        end else if (clear) begin
            idx_i <= ZERO;
            idx_j <= ZERO;
            idx_k <= ZERO;
        end else if (advance_ik) begin
            idx_j <= ZERO;
            if (last_k) begin
                idx_k <= ZERO;
                idx_i <= idx_i + ONE;
            end else begin
                idx_k <= idx_k + ONE;
            end
        end else if (advance_j) begin
            idx_j <= idx_j + ONE;
        end
    end

endmodule

// File: rtl/accelerator_read_heads_scheduler.sv
// DNC read-vector scheduler: r(i,k) = sum_j M(j,k)*w(i,j) for all heads.
// ACCELERATOR_READ_HEADS_SCHEDULER_SATURATE_EN: wide accumulator + clamped result; otherwise wrapping.
module accelerator_read_heads_scheduler
    import accelerator_read_heads_scheduler_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input logic                                  CLK,
    input logic                                  RST,
    accelerator_read_heads_scheduler_if.master   bus
);

`ifdef ACCELERATOR_READ_HEADS_SCHEDULER_SATURATE_EN
    localparam int PROD_W = 2 * DATA_SIZE;
    // Guard bits cover up to 2^CONTROL_SIZE summed products without wrapping.
    localparam int ACC_W  = 2 * DATA_SIZE + CONTROL_SIZE;
`else
    localparam int PROD_W = DATA_SIZE;
    localparam int ACC_W  = DATA_SIZE;
`endif

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_EMIT = EMIT;
    localparam logic [1:0] ST_DONE = DONE;

    localparam logic [CONTROL_SIZE-1:0] ZERO_C = ZERO_CONTROL[CONTROL_SIZE-1:0];
    localparam logic [DATA_SIZE-1:0]    ZERO_D = ZERO_DATA[DATA_SIZE-1:0];

`ifdef ACCELERATOR_READ_HEADS_SCHEDULER_SATURATE_EN
    function automatic logic signed [DATA_SIZE-1:0] finish_sum(input logic signed [ACC_W-1:0] v);
        logic signed [CONST_W-1:0] wide;
        logic signed [CONST_W-1:0] hi;
        logic signed [CONST_W-1:0] lo;
        wide = CONST_W'(v);
        hi   = sat_max(DATA_SIZE);
        lo   = sat_min(DATA_SIZE);
        if (wide > hi)
            return hi[DATA_SIZE-1:0];
        else if (wide < lo)
            return lo[DATA_SIZE-1:0];
        else
            return v[DATA_SIZE-1:0];
    endfunction
`else
    function automatic logic signed [DATA_SIZE-1:0] finish_sum(input logic signed [ACC_W-1:0] v);
        return v;
    endfunction
`endif

    logic                    [1:0] state;
    logic       [CONTROL_SIZE-1:0] size_r;
    logic       [CONTROL_SIZE-1:0] size_n;
    logic       [CONTROL_SIZE-1:0] size_w;
    logic signed      [ACC_W-1:0]  acc;
    logic signed      [ACC_W-1:0]  acc_next;
    logic signed     [PROD_W-1:0]  product;
    logic signed  [DATA_SIZE-1:0]  r_out;
    logic       [CONTROL_SIZE-1:0] r_i;
    logic       [CONTROL_SIZE-1:0] r_k;

    logic                    size_zero;
    logic                    accept_start;
    logic                    clear;
    logic                    advance_j;
    logic                    advance_ik;
    logic [CONTROL_SIZE-1:0] idx_i;
    logic [CONTROL_SIZE-1:0] idx_j;
    logic [CONTROL_SIZE-1:0] idx_k;
    logic                    last_j;
    logic                    last_ik;

    assign size_zero    = (bus.SIZE_R_IN == ZERO_C) || (bus.SIZE_N_IN == ZERO_C) ||
                          (bus.SIZE_W_IN == ZERO_C);
    assign accept_start = (state == ST_IDLE) && bus.START;
    assign clear        = accept_start && !size_zero;
    assign advance_j    = (state == ST_REQ) && bus.OP_VALID && !last_j;
    assign advance_ik   = (state == ST_EMIT);

    // Product width follows the build: full width when saturating, low half when wrapping.
    assign product  = bus.M_IN * bus.W_IN;
    assign acc_next = acc + ACC_W'(product);

    accelerator_nested_index_counter #(
        .CONTROL_SIZE (CONTROL_SIZE)
    ) u_index (
        .CLK        (CLK),
        .RST        (RST),
        .size_r     (size_r),
        .size_n     (size_n),
        .size_w     (size_w),
        .clear      (clear),
        .advance_j  (advance_j),
        .advance_ik (advance_ik),
        .idx_i      (idx_i),
        .idx_j      (idx_j),
        .idx_k      (idx_k),
        .last_j     (last_j),
        .last_ik    (last_ik)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_IDLE;
            size_r <= ZERO_C;
            size_n <= ZERO_C;
            size_w <= ZERO_C;
            acc    <= '0;
            r_out  <= ZERO_D;
            r_i    <= ZERO_C;
            r_k    <= ZERO_C;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.START) begin
                        if (size_zero) begin
                            state <= ST_DONE;
                        end else begin
                            size_r <= bus.SIZE_R_IN;
                            size_n <= bus.SIZE_N_IN;
                            size_w <= bus.SIZE_W_IN;
                            acc    <= '0;
                            state  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.OP_VALID) begin
                        acc <= acc_next;
                        // Result is registered on the final operand so it is valid throughout EMIT.
                        if (last_j) begin
                            r_out <= finish_sum(acc_next);
                            r_i   <= idx_i;
                            r_k   <= idx_k;
                            state <= ST_EMIT;
                        end
                    end
                end
                ST_EMIT: begin
                    acc   <= '0;
                    state <= last_ik ? ST_DONE : ST_REQ;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.BUSY     = (state != ST_IDLE);
    assign bus.OP_REQ   = (state == ST_REQ);
    assign bus.R_VALID  = (state == ST_EMIT);
    assign bus.READY    = (state == ST_DONE);
    assign bus.OP_I_OUT = idx_i;
    assign bus.OP_J_OUT = idx_j;
    assign bus.OP_K_OUT = idx_k;
    assign bus.R_OUT    = r_out;
    assign bus.R_I_OUT  = r_i;
    assign bus.R_K_OUT  = r_k;

endmodule

// File: tb/tb_accelerator_read_heads_scheduler.sv
// Table-driven bench for accelerator_read_heads_scheduler with an operand responder
// and a result scoreboard; expectations follow ACCELERATOR_READ_HEADS_SCHEDULER_SATURATE_EN.
module tb_accelerator_read_heads_scheduler;

    localparam int DS = 8;
    localparam int CS = 8;
    localparam int BUDGET = 200;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    accelerator_read_heads_scheduler_if #(.DATA_SIZE(DS), .CONTROL_SIZE(CS)) bus ();

    accelerator_read_heads_scheduler #(
        .DATA_SIZE    (DS),
        .CONTROL_SIZE (CS)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    typedef struct {
        string name;
        int    r;
        int    n;
        int    w;
        int    pat;
        int    stall_at;
        int    stall_len;
        int    busy_start;
        int    exp_cycles;
    } vec_t;

    typedef struct {
        logic signed [DS-1:0] val;
        logic        [CS-1:0] i;
        logic        [CS-1:0] k;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [DS-1:0] m_of(input int pat, input int j, input int k);
        case (pat)
            0:       return (j == 0) ? 8'sd3 : 8'sd5;
            1:       return 8'sd1;
            2:       return 8'sd100;
            3:       return DS'(j * 3 - k * 5 + 1);
            default: return DS'(50 * j - 90 + 13 * k);
        endcase
    endfunction

    function automatic logic signed [DS-1:0] w_of(input int pat, input int i, input int j);
        case (pat)
            0:       return (j == 0) ? 8'sd2 : 8'sd4;
            1:       return 8'sd1;
            2:       return 8'sd2;
            3:       return DS'(i * 7 - j * 2 - 3);
            default: return DS'(37 * i - 60 + 11 * j);
        endcase
    endfunction

    task automatic push_expected(input vec_t v);
        for (int i = 0; i < v.r; i++) begin
            for (int k = 0; k < v.w; k++) begin
                longint s;
                exp_t   e;
                s = 0;
                for (int j = 0; j < v.n; j++)
                    s += longint'(m_of(v.pat, j, k)) * longint'(w_of(v.pat, i, j));
`ifdef ACCELERATOR_READ_HEADS_SCHEDULER_SATURATE_EN
                if (s > 127)       e.val = 8'sd127;
                else if (s < -128) e.val = -8'sd128;
                else               e.val = s[DS-1:0];
`else
                e.val = s[DS-1:0];
`endif
                e.i = CS'(i);
                e.k = CS'(k);
                sb.push_back(e);
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int                   cyc;
        int                   ready_cyc;
        int                   req_seen;
        int                   req_cnt;
        logic [3*CS-1:0]      held;
        logic signed [DS-1:0] last_val;
        bit                   have_last;
        exp_t                 e;
        bit                   nonzero;

        nonzero   = (v.r != 0) && (v.n != 0) && (v.w != 0);
        ready_cyc = 0;
        req_seen  = 0;
        req_cnt   = 0;
        have_last = 1'b0;
        last_val  = '0;
        held      = '0;
        if (nonzero) push_expected(v);

        @(negedge CLK);
        bus.SIZE_R_IN = CS'(v.r);
        bus.SIZE_N_IN = CS'(v.n);
        bus.SIZE_W_IN = CS'(v.w);
        bus.START     = 1'b1;
        bus.OP_VALID  = 1'b0;
        @(negedge CLK);
        bus.START     = 1'b0;
        // Sizes are only latched on the accepted START.
        bus.SIZE_R_IN = 8'd3;
        bus.SIZE_N_IN = 8'd3;
        bus.SIZE_W_IN = 8'd3;
        cyc = 1;
        check({v.name, "/busy_after_start"}, 64'(bus.BUSY), 64'd1);

        while (1) begin
            if (bus.R_VALID) begin
                if (sb.size() == 0) begin
                    check({v.name, "/r_valid_extra"}, 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check({v.name, "/r_out"}, 64'(bus.R_OUT), 64'(e.val));
                    check({v.name, "/r_i"}, 64'(bus.R_I_OUT), 64'(e.i));
                    check({v.name, "/r_k"}, 64'(bus.R_K_OUT), 64'(e.k));
                    last_val  = e.val;
                    have_last = 1'b1;
                end
            end
            if (bus.READY) begin
                ready_cyc = cyc;
                break;
            end
            if (bus.OP_REQ) begin
                req_cnt++;
                if (v.stall_len > 0 && req_seen == v.stall_at)
                    held = {bus.OP_I_OUT, bus.OP_J_OUT, bus.OP_K_OUT};
                if (v.stall_len > 0 && req_seen > v.stall_at && req_seen <= v.stall_at + v.stall_len)
                    check({v.name, "/stall_idx_hold"}, 64'({bus.OP_I_OUT, bus.OP_J_OUT, bus.OP_K_OUT}),
                          64'(held));
                if (v.stall_len > 0 && req_seen >= v.stall_at && req_seen < v.stall_at + v.stall_len) begin
                    bus.OP_VALID = 1'b0;
                    bus.M_IN     = DS'($urandom);
                    bus.W_IN     = DS'($urandom);
                end else begin
                    bus.OP_VALID = 1'b1;
                    bus.M_IN     = m_of(v.pat, int'(bus.OP_J_OUT), int'(bus.OP_K_OUT));
                    bus.W_IN     = w_of(v.pat, int'(bus.OP_I_OUT), int'(bus.OP_J_OUT));
                end
                req_seen++;
            end else begin
                // Junk strobes outside REQ must be ignored.
                bus.OP_VALID = 1'($urandom);
                bus.M_IN     = DS'($urandom);
                bus.W_IN     = DS'($urandom);
            end
            bus.START = (cyc == v.busy_start);
            @(negedge CLK);
            cyc++;
            if (cyc > BUDGET) begin
                check({v.name, "/timeout"}, 64'd1, 64'd0);
                break;
            end
        end

        bus.START    = 1'b0;
        bus.OP_VALID = 1'b0;
        check({v.name, "/ready_cycle"}, 64'(ready_cyc), 64'(v.exp_cycles));
        check({v.name, "/req_cycles"}, 64'(req_cnt),
              nonzero ? 64'(v.r * v.w * v.n + v.stall_len) : 64'd0);
        check({v.name, "/sb_drained"}, 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge CLK);
        check({v.name, "/idle_after_ready"}, 64'({bus.BUSY, bus.READY}), 64'd0);
        if (have_last)
            check({v.name, "/r_out_held"}, 64'(bus.R_OUT), 64'(last_val));
    endtask

    initial begin
        int readys;

        vecs[0] = '{"basic",        1, 2, 1, 0, 0, 0, 0,  4};
        vecs[1] = '{"ordering",     2, 1, 2, 1, 0, 0, 0,  9};
        vecs[2] = '{"backpressure", 1, 4, 2, 4, 2, 3, 0, 14};
        vecs[3] = '{"overflow",     1, 2, 1, 2, 0, 0, 2,  4};
        vecs[4] = '{"mixed",        2, 3, 2, 3, 0, 0, 5, 17};
        vecs[5] = '{"wide_stall",   3, 3, 2, 4, 7, 1, 0, 26};
        vecs[6] = '{"zero_n",       2, 0, 2, 1, 0, 0, 0,  1};
        vecs[7] = '{"zero_r",       0, 3, 1, 1, 0, 0, 0,  1};
        vecs[8] = '{"basic_again",  1, 2, 1, 0, 0, 0, 0,  4};

        RST           = 1'b1;
        bus.START     = 1'b0;
        bus.SIZE_R_IN = '0;
        bus.SIZE_N_IN = '0;
        bus.SIZE_W_IN = '0;
        bus.OP_VALID  = 1'b0;
        bus.M_IN      = '0;
        bus.W_IN      = '0;
        repeat (2) @(negedge CLK);
        check("reset/ctrl", 64'({bus.OP_REQ, bus.BUSY, bus.READY, bus.R_VALID}), 64'd0);
        check("reset/r_out", 64'(bus.R_OUT), 64'd0);
        check("reset/idx", 64'({bus.OP_I_OUT, bus.OP_J_OUT, bus.OP_K_OUT, bus.R_I_OUT, bus.R_K_OUT}), 64'd0);
        RST = 1'b0;

        for (int t = 0; t < 9; t++)
            run_vec(vecs[t]);

        // Abort a run mid-sum; R_OUT still holds the previous result going in.
        @(negedge CLK);
        bus.SIZE_R_IN = 8'd1;
        bus.SIZE_N_IN = 8'd4;
        bus.SIZE_W_IN = 8'd1;
        bus.START     = 1'b1;
        @(negedge CLK);
        bus.START    = 1'b0;
        bus.OP_VALID = 1'b1;
        bus.M_IN     = 8'sd7;
        bus.W_IN     = 8'sd3;
        repeat (2) @(negedge CLK);
        check("abort/busy_before", 64'({bus.BUSY, bus.OP_REQ}), 64'd3);
        RST = 1'b1;
        #1;
        check("abort/ctrl", 64'({bus.OP_REQ, bus.BUSY, bus.READY, bus.R_VALID}), 64'd0);
        check("abort/r_out", 64'(bus.R_OUT), 64'd0);
        check("abort/idx", 64'({bus.OP_I_OUT, bus.OP_J_OUT, bus.OP_K_OUT, bus.R_I_OUT, bus.R_K_OUT}), 64'd0);
        @(negedge CLK);
        RST    = 1'b0;
        readys = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (bus.READY) readys++;
        end
        check("abort/no_ready", 64'(readys), 64'd0);
        bus.OP_VALID = 1'b0;

        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
